// File: rtl/period_meter_pkg.sv
// Shared types and helpers for the period meter: measurement modes, FSM
// states and the prescaler sizing rule.
package period_meter_pkg;

  // Measurement quantity latched when a measurement is accepted.
  typedef enum logic [1:0] {
    MODE_PERIOD = 2'b00,
    MODE_HIGH   = 2'b01,
    MODE_LOW    = 2'b10
  } mode_t;

  // Measurement controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARM     = 2'b01,
    MEASURE = 2'b10,
    DONE    = 2'b11
  } state_t;

  // Prescaler width for a given tick length; a one-cycle tick still needs
  // a one-bit register so the counter logic stays uniform.
  function automatic int presc_width(input int clk_per_tick);
    if (clk_per_tick > 1) begin
      return $clog2(clk_per_tick);
    end
    return 1;
  endfunction

  // Raw mode pins to a measurement mode; the unused code 11 measures period.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_HIGH;
      2'b10:   return MODE_LOW;
      default: return MODE_PERIOD;
    endcase
  endfunction

endpackage

// File: rtl/period_meter_edge_sync.sv
// Synchroniser for the asynchronous measured signal plus one delay flop.
// Rise and fall are single-cycle pulses derived from the same two flops,
// so both edges see the identical latency and it cancels out of any
// edge-to-edge interval.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   delay_reg;
  logic                   sync_out;

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // Shift the pin through the synchroniser chain, then delay one more cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg  <= '0;
      delay_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      delay_reg <= sync_out;
    end
  end

  assign rise = sync_out & ~delay_reg;
  assign fall = ~sync_out & delay_reg;

endmodule

// File: rtl/period_meter.sv
// Period / high-time / low-time meter with tick prescaler, optional
// power-of-two averaging and saturation reporting.
//
// Interval accounting: the cycle on which the opening edge is detected is
// the first cycle of the interval, so after that edge the prescaler holds
// the count for the second cycle. A tick is credited on the cycle that
// completes it, unless that cycle is the closing edge, in which case the
// edge wins. An interval of k cycles therefore yields floor(k/CLK_PER_TICK),
// and in period mode the closing rise doubles as the next opening rise
// without losing a cycle.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CLK_PER_TICK = 100,
  parameter int COUNT_W      = 24,
  parameter int AVG_LOG2     = 0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sig_in,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  output logic [COUNT_W-1:0] result,
  output logic               done,
  output logic               busy,
  output logic               overflow
);

  localparam int PW      = presc_width(CLK_PER_TICK);
  localparam int ACC_W   = COUNT_W + AVG_LOG2;
  localparam int IDX_W   = AVG_LOG2 + 1;
  localparam int SAMPLES = 1 << AVG_LOG2;

  localparam logic [PW-1:0]      PRESC_LAST  = PW'(CLK_PER_TICK - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(SAMPLES - 1);
  // Counter values right after an opening edge: the edge cycle itself has
  // already been counted (and completes a whole tick when a tick is one cycle).
  localparam logic [PW-1:0]      PRESC_START = (CLK_PER_TICK == 1) ? PW'(0) : PW'(1);
  localparam logic [COUNT_W-1:0] UNITS_START = (CLK_PER_TICK == 1) ? COUNT_W'(1) : COUNT_W'(0);

  // ---------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------
  logic rise;
  logic fall;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t             state_reg;
  mode_t              mode_reg;
  logic [PW-1:0]      presc_reg;
  logic [COUNT_W-1:0] units_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [COUNT_W-1:0] result_reg;
  logic               done_reg;
  logic               busy_reg;
  logic               overflow_reg;

  // ---------------------------------------------------------------------
  // Derived per-cycle conditions
  // ---------------------------------------------------------------------
  logic               open_edge;
  logic               close_edge;
  logic               tick_term;
  logic               units_full;
  logic [PW-1:0]      presc_next;
  logic [COUNT_W-1:0] units_next;
  logic [ACC_W-1:0]   acc_sum;
  logic               last_sample;

  // Edge selection, prescaler step and accumulator sum for the current cycle.
  always_comb begin
    open_edge   = (mode_reg == MODE_LOW)  ? fall : rise;
    close_edge  = (mode_reg == MODE_HIGH) ? fall : rise;
    tick_term   = (presc_reg == PRESC_LAST);
    units_full  = &units_reg;
    presc_next  = tick_term ? '0 : presc_reg + 1'b1;
    units_next  = units_reg + 1'b1;
    acc_sum     = acc_reg + ACC_W'(units_reg);
    last_sample = (idx_reg == IDX_LAST);
  end

  // ---------------------------------------------------------------------
  // Measurement controller with registered outputs
  // ---------------------------------------------------------------------

  // Sequence IDLE -> ARM -> MEASURE -> DONE, counting ticks and averaging.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      mode_reg     <= MODE_PERIOD;
      presc_reg    <= '0;
      units_reg    <= '0;
      acc_reg      <= '0;
      idx_reg      <= '0;
      result_reg   <= '0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            state_reg    <= ARM;
            mode_reg     <= decode_mode(mode);
            overflow_reg <= 1'b0;
            acc_reg      <= '0;
            idx_reg      <= '0;
            busy_reg     <= 1'b1;
          end
        end

        ARM: begin
          if (abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (open_edge) begin
            state_reg <= MEASURE;
            presc_reg <= PRESC_START;
            units_reg <= UNITS_START;
          end
        end

        MEASURE: begin
          if (abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (close_edge) begin
            // Closing edge: bank this sample; a tick ending here is dropped.
            acc_reg <= acc_sum;
            idx_reg <= idx_reg + 1'b1;
            if (last_sample) begin
              state_reg  <= DONE;
              result_reg <= COUNT_W'(acc_sum >> AVG_LOG2);
              done_reg   <= 1'b1;
              busy_reg   <= 1'b0;
            end else if (mode_reg == MODE_PERIOD) begin
              // The same rise opens the next period back to back.
              presc_reg <= PRESC_START;
              units_reg <= UNITS_START;
            end else begin
              state_reg <= ARM;
            end
          end else if (tick_term && units_full) begin
            // One tick more than the counter holds: saturate and finish now.
            state_reg    <= DONE;
            overflow_reg <= 1'b1;
            result_reg   <= '1;
            done_reg     <= 1'b1;
            busy_reg     <= 1'b0;
          end else begin
            presc_reg <= presc_next;
            if (tick_term) begin
              units_reg <= units_next;
            end
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign result   = result_reg;
  assign done     = done_reg;
  assign busy     = busy_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: three instances (plain, 4-sample average, 8-bit
// counter) driven with directed waveforms. A behavioural model predicts each
// result from the interval lengths; one compare process checks every cycle.
module tb_period_meter;

  localparam int CPT = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  sig;
  logic [2:0]  start;
  logic [2:0]  abort;
  logic [2:0]  done;
  logic [2:0]  busy;
  logic [2:0]  ovf;
  logic [1:0]  mode_v [3];
  logic [23:0] res_a;
  logic [23:0] res_b;
  logic [7:0]  res_c;

  int     errors = 0;
  int     checks = 0;
  longint exp_result [3];
  bit     exp_ovf    [3];
  bit     pending    [3];
  bit     track      [3];
  int     done_cnt   [3];
  int     iv         [4];

  always #5 clk = ~clk;

  period_meter #(.CLK_PER_TICK(CPT), .COUNT_W(24), .AVG_LOG2(0), .SYNC_STAGES(2)) u_a (
    .clk(clk), .reset_n(reset_n), .sig_in(sig[0]), .start(start[0]), .abort(abort[0]),
    .mode(mode_v[0]), .result(res_a), .done(done[0]), .busy(busy[0]), .overflow(ovf[0]));

  period_meter #(.CLK_PER_TICK(CPT), .COUNT_W(24), .AVG_LOG2(2), .SYNC_STAGES(2)) u_b (
    .clk(clk), .reset_n(reset_n), .sig_in(sig[1]), .start(start[1]), .abort(abort[1]),
    .mode(mode_v[1]), .result(res_b), .done(done[1]), .busy(busy[1]), .overflow(ovf[1]));

  period_meter #(.CLK_PER_TICK(CPT), .COUNT_W(8), .AVG_LOG2(0), .SYNC_STAGES(3)) u_c (
    .clk(clk), .reset_n(reset_n), .sig_in(sig[2]), .start(start[2]), .abort(abort[2]),
    .mode(mode_v[2]), .result(res_c), .done(done[2]), .busy(busy[2]), .overflow(ovf[2]));

  function automatic int cw(input int ch);
    return (ch == 2) ? 8 : 24;
  endfunction

  function automatic int al(input int ch);
    return (ch == 1) ? 2 : 0;
  endfunction

  function automatic longint get_res(input int ch);
    case (ch)
      0:       return longint'(res_a);
      1:       return longint'(res_b);
      default: return longint'(res_c);
    endcase
  endfunction

  task automatic chk(input string name, input int ch, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %0d expected %0d at %0t", name, ch, act, exp, $time);
    end
  endtask

  // Model: each interval of k cycles is worth k/CPT ticks; a sample beyond
  // the counter range saturates; otherwise the mean of the samples.
  function automatic void model_predict(input int ch, input int n);
    longint maxv;
    longint sum;
    bit     ov;
    maxv = (longint'(1) << cw(ch)) - 1;
    sum  = 0;
    ov   = 1'b0;
    for (int i = 0; i < n; i++) begin
      longint s;
      s = longint'(iv[i] / CPT);
      if (s > maxv) ov = 1'b1;
      sum += s;
    end
    exp_ovf[ch]    = ov;
    exp_result[ch] = ov ? maxv : (sum >> al(ch));
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (done[ch]) begin
          chk("done_expected", ch, longint'(pending[ch]), 1);
          chk("done_result", ch, get_res(ch), exp_result[ch]);
          chk("done_overflow", ch, longint'(ovf[ch]), longint'(exp_ovf[ch]));
          chk("done_busy_low", ch, longint'(busy[ch]), 0);
          done_cnt[ch]++;
          pending[ch] = 1'b0;
          track[ch]   = 1'b0;
        end else if (!pending[ch]) begin
          chk("hold_result", ch, get_res(ch), exp_result[ch]);
          chk("idle_busy", ch, longint'(busy[ch]), 0);
          chk("hold_overflow", ch, longint'(ovf[ch]), longint'(exp_ovf[ch]));
        end else if (track[ch]) begin
          chk("busy_high", ch, longint'(busy[ch]), 1);
        end
      end
    end
  end

  task automatic level(input int ch, input bit lvl, input int cyc);
    sig[ch] = lvl;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic do_start(input int ch, input logic [1:0] m, input int n);
    @(negedge clk);
    mode_v[ch]  = m;
    start[ch]   = 1'b1;
    pending[ch] = 1'b1;
    if (n > 0) model_predict(ch, n);
    else exp_ovf[ch] = 1'b0;
    @(negedge clk);
    start[ch] = 1'b0;
    track[ch] = 1'b1;
  endtask

  // Back-to-back periods from iv[], each split half high / half low.
  task automatic run_period(input int ch, input int n);
    level(ch, 1'b0, 4);
    for (int i = 0; i < n; i++) begin
      level(ch, 1'b1, iv[i] / 2);
      level(ch, 1'b0, iv[i] - iv[i] / 2);
    end
    sig[ch] = 1'b1;
  endtask

  task automatic wait_done(input int ch, input int budget, output int elapsed);
    int c0;
    c0 = done_cnt[ch];
    elapsed = 0;
    while (done_cnt[ch] == c0 && elapsed < budget) begin
      @(negedge clk);
      elapsed++;
    end
    chk("done_arrives", ch, longint'(done_cnt[ch] != c0), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int el;
    sig     = '0;
    start   = '0;
    abort   = '0;
    mode_v  = '{default: 2'b00};
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    for (int ch = 0; ch < 3; ch++) begin
      chk("reset_result", ch, get_res(ch), 0);
      chk("reset_done", ch, longint'(done[ch]), 0);
      chk("reset_busy", ch, longint'(busy[ch]), 0);
      chk("reset_ovf", ch, longint'(ovf[ch]), 0);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Period 500 cycles -> 50 ticks.
    iv[0] = 500;
    do_start(0, 2'b00, 1);
    run_period(0, 1);
    wait_done(0, 40, el);
    chk("lit_period", 0, get_res(0), 50);
    repeat (10) @(negedge clk);

    // High time 300 of a 1000-cycle period; a start mid-measure is ignored.
    iv[0] = 300;
    do_start(0, 2'b01, 1);
    level(0, 1'b0, 4);
    sig[0] = 1'b1;
    repeat (100) @(negedge clk);
    mode_v[0] = 2'b10;
    start[0]  = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (199) @(negedge clk);
    sig[0] = 1'b0;
    wait_done(0, 40, el);
    chk("lit_high", 0, get_res(0), 30);
    repeat (10) @(negedge clk);

    // Low time 700 cycles.
    sig[0] = 1'b1;
    repeat (10) @(negedge clk);
    iv[0] = 700;
    do_start(0, 2'b10, 1);
    level(0, 1'b1, 4);
    level(0, 1'b0, 700);
    sig[0] = 1'b1;
    wait_done(0, 40, el);
    chk("lit_low", 0, get_res(0), 70);
    repeat (10) @(negedge clk);

    // 149 cycles: the 15th tick ends on the closing edge and is dropped.
    iv[0] = 149;
    do_start(0, 2'b00, 1);
    run_period(0, 1);
    wait_done(0, 40, el);
    chk("lit_149", 0, get_res(0), 14);
    repeat (10) @(negedge clk);

    // 150 cycles, mode code 11 measures period.
    iv[0] = 150;
    do_start(0, 2'b11, 1);
    run_period(0, 1);
    wait_done(0, 40, el);
    chk("lit_150", 0, get_res(0), 15);
    repeat (10) @(negedge clk);

    // Four-sample average of 10/20/30/40 ticks.
    iv[0] = 100; iv[1] = 200; iv[2] = 300; iv[3] = 400;
    do_start(1, 2'b00, 4);
    run_period(1, 4);
    wait_done(1, 40, el);
    chk("lit_avg", 1, get_res(1), 25);
    repeat (10) @(negedge clk);

    // 8-bit counter, 300-tick period: saturates at tick 256, before the edge.
    iv[0] = 3000;
    do_start(2, 2'b00, 1);
    level(2, 1'b0, 4);
    sig[2] = 1'b1;
    wait_done(2, 2800, el);
    chk("ovf_timing_window", 2, longint'(el >= 2560 && el <= 2570), 1);
    chk("lit_ovf_result", 2, get_res(2), 255);
    chk("lit_ovf_flag", 2, longint'(ovf[2]), 1);
    level(2, 1'b0, 20);

    // Next start clears overflow; 200 cycles -> 20 ticks.
    iv[0] = 200;
    do_start(2, 2'b00, 1);
    chk("ovf_cleared", 2, longint'(ovf[2]), 0);
    run_period(2, 1);
    wait_done(2, 40, el);
    chk("lit_after_ovf", 2, get_res(2), 20);
    repeat (10) @(negedge clk);

    // Abort mid-MEASURE: busy drops next cycle, no done, result stays 15.
    do_start(0, 2'b00, 0);
    level(0, 1'b0, 4);
    sig[0] = 1'b1;
    repeat (50) @(negedge clk);
    abort[0] = 1'b1;
    track[0] = 1'b0;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort_busy_low", 0, longint'(busy[0]), 0);
    pending[0] = 1'b0;
    level(0, 1'b0, 30);
    level(0, 1'b1, 30);
    level(0, 1'b0, 30);
    chk("lit_abort_hold", 0, get_res(0), 15);

    // Start and abort together in IDLE: abort wins, nothing starts.
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    level(0, 1'b1, 30);
    level(0, 1'b0, 30);

    // Reset mid-MEASURE clears every output immediately.
    do_start(0, 2'b00, 0);
    level(0, 1'b0, 4);
    sig[0] = 1'b1;
    repeat (60) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      exp_result[ch] = 0;
      exp_ovf[ch]    = 1'b0;
      pending[ch]    = 1'b0;
      track[ch]      = 1'b0;
    end
    #1;
    for (int ch = 0; ch < 3; ch++) begin
      chk("midreset_result", ch, get_res(ch), 0);
      chk("midreset_busy", ch, longint'(busy[ch]), 0);
      chk("midreset_done", ch, longint'(done[ch]), 0);
      chk("midreset_ovf", ch, longint'(ovf[ch]), 0);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    sig[0] = 1'b0;
    repeat (5) @(negedge clk);

    // Normal operation after reset: 120 cycles -> 12 ticks.
    iv[0] = 120;
    do_start(0, 2'b00, 1);
    run_period(0, 1);
    wait_done(0, 40, el);
    chk("lit_after_reset", 0, get_res(0), 12);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
